// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector with registered match pulse and saturating match counter.
// Optional idle timeout that drops partial history: define SEQ_DETECTOR_PROG_TIMEOUT_EN.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN+1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(8'b0000_1101),
  parameter int                 DEFAULT_LEN = 4,
  parameter int                 TIMEOUT     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               overlap_en,
  input  logic               clr_cnt,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat, hist, hist_sh, mask;
  logic [LEN_W-1:0]   len, fill, fill_inc;
  logic               cfg_ok, hit, idle_clr;

  always_comb begin
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    hist_sh  = {hist[MAX_LEN-2:0], x};
    fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len);
    // A bit arriving alongside a config write is discarded, so it can never complete a match.
    hit = x_valid && !cfg_we && (fill_inc >= len) && ((hist_sh & mask) == (pat & mask));
  end

`ifdef SEQ_DETECTOR_PROG_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT+1);
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;

  always_comb begin
    idle_nxt = '0;
    if (!x_valid)
      idle_nxt = (idle_cnt == IDLE_W'(TIMEOUT)) ? idle_cnt : idle_cnt + 1'b1;
    idle_clr = !x_valid && (idle_nxt == IDLE_W'(TIMEOUT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_nxt;
  end
`else
  assign idle_clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat     <= DEFAULT_PAT;
      len     <= LEN_W'(DEFAULT_LEN);
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we) begin
        if (cfg_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          hist <= '0;
          fill <= '0;
        end
      end else if (x_valid) begin
        hist <= hist_sh;
        // Non-overlapping mode restarts the count so the next match needs len fresh bits.
        fill <= (hit && !overlap_en) ? '0 : fill_inc;
      end else if (idle_clr) begin
        hist <= '0;
        fill <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          match_cnt <= '0;
    else if (clr_cnt)                 match_cnt <= '0;
    else if (match && ~&match_cnt)    match_cnt <= match_cnt + 1'b1;
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Randomized + directed bench for seq_detector_prog against a bit-queue reference model.
module tb_seq_detector_prog;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst, x, x_valid, cfg_we, overlap_en, clr_cnt;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic       match, cfg_err, match2, cfg_err2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt), .cfg_err(cfg_err));

  seq_detector_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .clr_cnt(clr_cnt), .match(match2), .match_cnt(match_cnt2), .cfg_err(cfg_err2));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_match = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: the bits received since the last clear, oldest first.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len, m_cnt, m_cnt2, m_idle;
  bit         m_match, m_err;

  task automatic m_reset();
    q.delete();
    m_pat = 8'h0D; m_len = 4;
    m_match = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0; m_idle = 0;
  endtask

  task automatic model_edge();
    int nc, nc2;
    bit nm, ne, hit;
    nm = 0; ne = 0;
    nc  = clr_cnt ? 0 : (m_match && m_cnt  < 255) ? m_cnt  + 1 : m_cnt;
    nc2 = clr_cnt ? 0 : (m_match && m_cnt2 < 3)   ? m_cnt2 + 1 : m_cnt2;
    if (cfg_we) begin
      if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); q.delete();
      end else ne = 1;
    end else if (x_valid) begin
      q.push_back(x);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      hit = (q.size() >= m_len);
      for (int i = 0; i < m_len; i++)
        if (hit && q[q.size()-1-i] != m_pat[i]) hit = 0;
      if (hit) begin
        nm = 1;
        if (!overlap_en) q.delete();
      end
    end
`ifdef SEQ_DETECTOR_PROG_TIMEOUT_EN
    if (x_valid) m_idle = 0;
    else begin
      if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT && !cfg_we) q.delete();
    end
`endif
    m_match = nm; m_err = ne; m_cnt = nc; m_cnt2 = nc2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset(); else model_edge();
    #1;
    chk("match", match, m_match);
    chk("match2", match2, m_match);
    chk("match_cnt", match_cnt, m_cnt);
    chk("match_cnt_w2", match_cnt2, m_cnt2);
    chk("cfg_err", cfg_err, m_err);
    if (match) n_match++;
    cfg_we = 0; clr_cnt = 0; x_valid = 0;
  endtask

  task automatic bitv(input bit b);
    x = b; x_valid = 1; tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l);
    cfg_pattern = p; cfg_len = l; cfg_we = 1; tick();
  endtask

  task automatic clrc();
    clr_cnt = 1; tick();
  endtask

  task automatic feed(input logic [7:0] v, input int n);
    for (int i = n-1; i >= 0; i--) bitv(v[i]);
  endtask

  initial begin
    logic [7:0] tp;
    rst = 1; x = 0; x_valid = 0; cfg_we = 0; overlap_en = 1; clr_cnt = 0;
    cfg_pattern = '0; cfg_len = '0;
    m_reset();
    idle(2);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    rst = 0;

    // Default 1101, overlapping
    n_match = 0;
    feed(8'b0110_1101, 7);
    idle(2);
    chk("tp1_matches", n_match, 2);
    chk("tp1_cnt", match_cnt, 2);

    // Same stream, non-overlapping
    cfg(8'h0D, 4); clrc(); overlap_en = 0; n_match = 0;
    feed(8'b0110_1101, 7);
    idle(2);
    chk("tp2_matches", n_match, 1);
    chk("tp2_cnt", match_cnt, 1);

    // 8-bit pattern with valid gaps
    cfg(8'b1010_0111, 8); overlap_en = 1; n_match = 0;
    tp = 8'b1010_0111;
    for (int i = 7; i >= 1; i--) begin
      idle($urandom_range(0, 3));
      bitv(tp[i]);
    end
    idle($urandom_range(0, 3));
    chk("tp3_no_early", n_match, 0);
    bitv(tp[0]);
    chk("tp3_match", match, 1);
    idle(3);
    chk("tp3_single", n_match, 1);

    // Rejected writes keep 1101 config
    cfg(8'h0D, 4);
    cfg(8'hFF, 0);
    chk("tp4_err_len0", cfg_err, 1);
    cfg(8'hFF, 9);
    chk("tp4_err_len9", cfg_err, 1);
    tick();
    chk("tp4_err_pulse", cfg_err, 0);
    n_match = 0;
    feed(8'h0D, 4);
    chk("tp4_still_1101", n_match, 1);
    feed(8'b110, 3);
    x = 1; x_valid = 1; cfg_pattern = 8'h0D; cfg_len = 4; cfg_we = 1;
    tick();
    chk("tp4_cfg_discard", match, 0);

    // Counter saturation and clear priority
    cfg(8'h01, 1); clrc(); overlap_en = 0;
    feed(8'h1F, 5);
    idle(2);
    chk("tp5_sat_w2", match_cnt2, 3);
    chk("tp5_cnt", match_cnt, 5);
    bitv(1);
    clr_cnt = 1; tick();
    chk("tp5_clr_cnt", match_cnt, 0);
    chk("tp5_clr_cnt_w2", match_cnt2, 0);
    overlap_en = 1;
    repeat (300) bitv(1);
    idle(2);
    chk("sat_cnt", match_cnt, 255);

    // Idle gap handling
    cfg(8'h0D, 4); n_match = 0;
    feed(8'b110, 3); idle(16); bitv(1);
`ifdef SEQ_DETECTOR_PROG_TIMEOUT_EN
    chk("gap16", n_match, 0);
`else
    chk("gap16", n_match, 1);
`endif
    cfg(8'h0D, 4); n_match = 0;
    feed(8'b110, 3); idle(15); bitv(1);
    chk("gap15", n_match, 1);

    // Random traffic
    repeat (4000) begin
      if ($urandom_range(0, 99) < 2) begin
        cfg_we = 1;
        cfg_pattern = 8'($urandom);
        cfg_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 7) == 0) overlap_en = ~overlap_en;
      clr_cnt = ($urandom_range(0, 49) == 0);
      x_valid = ($urandom_range(0, 3) != 0);
      x = 1'($urandom);
      tick();
      if ($urandom_range(0, 299) == 0) idle($urandom_range(14, 18));
    end

    // Asynchronous reset mid-stream
    bitv(1);
    #2 rst = 1;
    #1;
    chk("arst_match", match, 0);
    chk("arst_cnt", match_cnt, 0);
    chk("arst_err", cfg_err, 0);
    m_reset();
    tick();
    rst = 0; overlap_en = 1; n_match = 0;
    feed(8'h0D, 4);
    chk("arst_default_pat", n_match, 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Parametrised, runtime-programmable serial sequence detector; successor to the fixed 4-bit Moore detector.
- Pattern length 1..MAX_LEN and pattern value are loaded at runtime.
- Overlapping and non-overlapping detection are selectable at runtime; a saturating match counter is provided.
- Sits on the serial bit path; `match` is a registered (Moore) output.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of length fields.
- CNT_W, 8, match counter width.
- DEFAULT_PAT, 8'b0000_1101, pattern loaded at reset (MAX_LEN bits, right-aligned).
- DEFAULT_LEN, 4, pattern length loaded at reset.
- TIMEOUT, 16, idle-cycle limit (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- x  in  1  serial data bit
- x_valid  in  1  x sampled this cycle when 1
- cfg_we  in  1  load cfg_pattern/cfg_len
- cfg_pattern  in  MAX_LEN  new pattern, right-aligned
- cfg_len  in  LEN_W  new pattern length
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping
- clr_cnt  in  1  synchronous clear of match_cnt
- match  out  1  one-cycle pulse, cycle after the completing bit
- match_cnt  out  CNT_W  saturating count of matches
- cfg_err  out  1  one-cycle pulse on a rejected config write

Behaviour:
- Reset (async, rst=1):
  - hist=0, fill=0, match=0, match_cnt=0, cfg_err=0.
  - pat=DEFAULT_PAT, len=DEFAULT_LEN.
- Bit order:
  - pat[len-1] is the first (oldest) bit; pat[0] is the last.
  - hist shifts left on each x_valid with x entering bit 0.
- fill:
  - Counts valid bits received since the last clear; saturates at MAX_LEN.
  - Cleared by a config write and by a non-overlapping match.
- Match condition, evaluated in cycle T when x_valid=1:
  - (fill+1) >= len, and
  - ({hist,x} low len bits) == pat low len bits.
- Match response:
  - match=1 in cycle T+1 only (latency 1, registered).
  - No match is possible in a cycle with x_valid=0; match returns to 0.
- After a match, by mode:
  - overlap_en=1: history kept; the next match can complete as early as 1 bit later (e.g. pattern 1111).
  - overlap_en=0: fill forced to 0 in the same update, so the next match needs len fresh bits.
- overlap_en is sampled per cycle; changing it mid-stream needs no flush.
- Config write (cfg_we=1):
  - Accepted when 1 <= cfg_len <= MAX_LEN: pat, len updated; hist and fill cleared next cycle.
  - Any x_valid bit in the same cycle is discarded; no match can fire from it.
  - Rejected when cfg_len == 0 or cfg_len > MAX_LEN: config, hist and fill unchanged; cfg_err=1 for one cycle.
- match_cnt:
  - Increments on each cycle match=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt has priority: when clr_cnt and match coincide, match_cnt becomes 0.
- len=1: every valid bit equal to pat[0] matches (when overlap_en=0, fill re-clears each time; same result).
- Reset asserted mid-stream: all state returns to reset values immediately; a pending match pulse is lost.

Optional Feature:
- Macro: SEQ_DETECTOR_PROG_TIMEOUT_EN.
- Defined:
  - Internal idle counter increments each cycle x_valid=0 and resets to 0 on x_valid=1.
  - After TIMEOUT consecutive idle cycles, hist and fill are cleared, so a partial pattern does not survive a long gap.
  - Config and counter behaviour are unchanged.
- Not defined: no idle counter; a partial history is held indefinitely across gaps.

Test Plan:
- Reset defaults (1101, len 4), overlap_en=1, stream 1,1,0,1,1,0,1 on consecutive valid cycles -> match pulses the cycle after bit 4 and after bit 7; match_cnt=2.
- Same stream with overlap_en=0 -> single match after bit 4; match_cnt=1.
- Write cfg_pattern=8'b1010_0111, cfg_len=8, then stream 1,0,1,0,0,1,1,1 with x_valid gaps of 0-3 cycles -> one match, one cycle after the last valid bit; no match in gap cycles.
- Write with cfg_len=0, then cfg_len=9 -> cfg_err pulses each time; pattern 1101 is still detected afterwards. cfg_we concurrent with a completing bit -> no match.
- CNT_W=2, feed 5 matches -> match_cnt sticks at 3. Assert clr_cnt in a match cycle -> match_cnt=0.
- With SEQ_DETECTOR_PROG_TIMEOUT_EN, TIMEOUT=16: feed 1,1,0, idle 16 cycles, then 1 -> no match. Repeat with 15 idle cycles -> match. Without the macro, the 16-cycle case -> match.
